// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared constants for the iterative RV32M multiply/divide unit:
//               operand width, funct3 op codes, FSM state encoding and small
//               op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // All divide/remainder ops have funct3[2] set.
    function automatic logic op_is_div(input logic [2:0] f);
        return f[2];
    endfunction

    // Operand A is treated as two's complement for these ops.
    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

    // Operand B is treated as two's complement for these ops.
    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == OP_MUL) || (f == OP_MULH) ||
               (f == OP_DIV) || (f == OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational iteration of the multiply/divide datapath.
//               Multiply: conditional add of i_b into the high half, then a
//               right shift of {carry, hi, lo}. Divide: restoring step that
//               shifts the next dividend bit into a 33-bit partial remainder
//               and subtracts the divisor when it fits.
// Ports       : i_is_div  1      select divide step (1) or multiply step (0)
//               i_hi      XLEN   product high half / partial remainder
//               i_lo      XLEN   multiplier bits    / dividend->quotient bits
//               i_b       XLEN   multiplicand       / divisor (magnitudes)
//               o_hi_nxt  XLEN   next high half / remainder
//               o_lo_nxt  XLEN   next low half  / quotient bits
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi_nxt,
    output logic [XLEN-1:0] o_lo_nxt
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    // Multiply: 33-bit sum so the carry out is shifted back into the high half.
    assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}});

    // Divide: the shifted partial remainder can reach 33 bits before the
    // compare. The remainder always stays below the divisor, so the
    // difference (when taken) fits back into XLEN bits.
    assign w_shift = {i_hi, i_lo[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, i_b});
    assign w_diff  = w_shift[XLEN-1:0] - i_b;

    always_comb begin
        o_hi_nxt = '0;
        o_lo_nxt = '0;
        if (i_is_div) begin
            o_hi_nxt = w_ge ? w_diff : w_shift[XLEN-1:0];
            o_lo_nxt = {i_lo[XLEN-2:0], w_ge};
        end else begin
            o_hi_nxt = w_sum[XLEN:1];
            o_lo_nxt = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit with fixed latency.
//               IDLE -> CALC (ITER_CYCLES steps) -> FIX -> DONE -> IDLE.
//               Operates on operand magnitudes; signs are applied in FIX.
// Ports       : clk     1   clock, rising edge
//               rst     1   synchronous active-high reset
//               start   1   request, sampled only in IDLE
//               op      3   RV32M funct3
//               rs1     32  operand A (dividend / multiplicand)
//               rs2     32  operand B (divisor / multiplier)
//               busy    1   high in CALC, FIX and DONE
//               done    1   one-cycle pulse, result valid
//               result  32  registered result, written only in FIX
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN        = 32,  // only 32 is supported
    parameter int ITER_CYCLES = 32   // must equal XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0] c_LAST_ITER = 5'(ITER_CYCLES - 1);

    logic [1:0]      r_state;
    logic [4:0]      r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic            r_sa;
    logic            r_sb;
    logic            r_div0;
    logic            r_ovf;
    logic [XLEN-1:0] r_result;

    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0] w_quo;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_fix_result;

    // Negation of 0x80000000 yields 0x80000000, which is the correct
    // magnitude when read as unsigned.
    assign w_sa    = op_a_signed(op) & rs1[XLEN-1];
    assign w_sb    = op_b_signed(op) & rs2[XLEN-1];
    assign w_abs_a = w_sa ? (~rs1 + 1'b1) : rs1;
    assign w_abs_b = w_sb ? (~rs2 + 1'b1) : rs2;

    muldiv_step u_step (
        .i_is_div (op_is_div(r_op)),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_b      (r_b),
        .o_hi_nxt (w_hi_nxt),
        .o_lo_nxt (w_lo_nxt)
    );

    // Sign correction. Quotient negates on differing signs; the remainder
    // follows the dividend.
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;
    assign w_quo    = (r_sa ^ r_sb) ? (~r_lo + 1'b1) : r_lo;
    assign w_rem    = r_sa ? (~r_hi + 1'b1) : r_hi;

    // With a zero divisor every restoring step succeeds, so the remainder
    // path already reproduces rs1; only the quotient needs overriding.
    always_comb begin
        w_fix_result = '0;
        case (r_op)
            OP_MUL:                        w_fix_result = w_prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_result = w_prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: begin
                if (r_div0)
                    w_fix_result = {XLEN{1'b1}};
                else if (r_ovf)
                    w_fix_result = {1'b1, {(XLEN-1){1'b0}}};
                else
                    w_fix_result = w_quo;
            end
            default: begin  // OP_REM, OP_REMU
                if (r_ovf)
                    w_fix_result = '0;
                else
                    w_fix_result = w_rem;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_div0   <= 1'b0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op   <= op;
                        r_hi   <= '0;
                        r_cnt  <= '0;
                        r_sa   <= w_sa;
                        r_sb   <= w_sb;
                        r_div0 <= op_is_div(op) && (rs2 == '0);
                        r_ovf  <= ((op == OP_DIV) || (op == OP_REM)) &&
                                  (rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                                  (rs2 == {XLEN{1'b1}});
                        // Multiply shifts the multiplier out of r_lo and adds
                        // the multiplicand; divide shifts the dividend out of
                        // r_lo and subtracts the divisor.
                        if (op_is_div(op)) begin
                            r_lo <= w_abs_a;
                            r_b  <= w_abs_b;
                        end else begin
                            r_lo <= w_abs_b;
                            r_b  <= w_abs_a;
                        end
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_ITER)
                        r_state <= FIX;
                end
                FIX: begin
                    r_result <= w_fix_result;
                    r_state  <= DONE;
                end
                default: begin  // DONE
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = (r_state == DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed corner cases
//               followed by randomized ops, compared against an arithmetic
//               reference of the RV32M rules, plus latency/busy/hold checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_result;
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        sxa, sxb, zxa, zxb, p;
        logic signed [31:0] x, y, q;
        logic               ovf;
        sxa = {{32{a[31]}}, a};
        sxb = {{32{b[31]}}, b};
        zxa = {32'h0, a};
        zxb = {32'h0, b};
        x   = a;
        y   = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sxa * sxb; return p[31:0];  end
            3'd1: begin p = sxa * sxb; return p[63:32]; end
            3'd2: begin p = sxa * zxb; return p[63:32]; end
            3'd3: begin p = zxa * zxb; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                q = x / y;
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                q = x % y;
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0)
            return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    // Issue one op in the current cycle (N) and follow it to completion.
    // inject=1 pulses start at N+5 and N+20, which must be ignored.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input string tag);
        logic [31:0] exp;
        int          done_at;
        int          busy_bad;
        int          hold_bad;
        int          extra_done;
        exp      = ref_model(f, a, b);
        op       = f;
        rs1      = a;
        rs2      = b;
        start    = 1'b1;
        check({tag, " busy_at_N"}, {31'h0, busy}, 32'h0);
        done_at  = 0;
        busy_bad = 0;
        hold_bad = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            @(posedge clk); #1;
            start = inject && (k == 5 || k == 20);
            op    = 3'($urandom);
            rs1   = $urandom;
            rs2   = $urandom;
            if (busy !== 1'b1) busy_bad++;
            if (k <= 33 && result !== last_result) hold_bad++;
            if (done === 1'b1) done_at = k;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(done_at), 32'd34);
        check({tag, " busy_span"}, 32'(busy_bad), 32'd0);
        check({tag, " result_hold"}, 32'(hold_bad), 32'd0);
        check({tag, " result"}, result, exp);
        @(posedge clk); #1;
        check({tag, " idle_after"}, {30'h0, busy, done}, 32'h0);
        last_result = exp;
        if (inject) begin
            extra_done = 0;
            for (int k = 0; k < 40; k++) begin
                if (done === 1'b1 || busy === 1'b1) extra_done++;
                @(posedge clk); #1;
            end
            check({tag, " no_second_op"}, 32'(extra_done), 32'd0);
            check({tag, " result_kept"}, result, exp);
        end
    endtask

    initial begin
        int extra;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        rs1   = 32'h0;
        rs2   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        rst = 1'b0;
        last_result = 32'h0;
        @(posedge clk); #1;

        // Directed cases
        do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 1'b0, "mul_7x-3");
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulh_min");
        do_op(3'd2, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulhsu_min");
        do_op(3'd3, 32'h8000_0000, 32'h8000_0000, 1'b0, "mulhu_min");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         1'b0, "div_-7/2");
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         1'b0, "rem_-7/2");
        do_op(3'd5, 32'd100,       32'd7,         1'b0, "divu_100/7");
        do_op(3'd7, 32'd100,       32'd7,         1'b0, "remu_100/7");
        do_op(3'd5, 32'd5,         32'd0,         1'b0, "divu_div0");
        do_op(3'd6, 32'd5,         32'd0,         1'b0, "rem_div0");
        do_op(3'd4, 32'hFFFF_FFF9, 32'd0,         1'b0, "div_neg_div0");
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
        do_op(3'd1, 32'd12345,     32'hFFFF_0000, 1'b1, "start_ignored");

        // Reset mid-CALC aborts the op without a done pulse
        op    = 3'd0;
        rs1   = 32'd9;
        rs2   = 32'd9;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_result", result, 32'h0);
        last_result = 32'h0;
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) extra++;
            @(posedge clk); #1;
        end
        check("abort_no_done", 32'(extra), 32'd0);
        do_op(3'd0, 32'd6, 32'd7, 1'b0, "after_abort");

        // Randomized ops with a bias toward corner operands
        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
